// File: rtl/simple_counter_checker_pkg.sv
// Shared types and default sizes for the counter checker.
package simple_counter_checker_pkg;

  localparam int unsigned DEFAULT_WIDTH        = 16;
  localparam int unsigned DEFAULT_ERRCNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } chk_state_e;

endpackage

// File: rtl/simple_counter_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the same
// cycle as a clear counts from zero, so the result is 1.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] base;

  // Next count: clear selects the base, increment applies on top unless saturated.
  always_comb begin
    base    = clr ? '0 : count_q;
    count_d = base;
    if (inc && (base != '1)) begin
      count_d = base + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/simple_counter_checker.sv
// Monitors an external counter: predicts its next value every cycle and
// flags cycles where the observed value disagrees with the prediction.
module simple_counter_checker
  import simple_counter_checker_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned ERRCNT_WIDTH = DEFAULT_ERRCNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mon_nreset,
  input  logic                    mon_enable,
  input  logic [WIDTH-1:0]        mon_data,
  input  logic                    clear_err,
  output logic                    locked,
  output logic                    mismatch,
  output logic                    error,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]        wraps,
  output logic [WIDTH-1:0]        expected
);

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] wraps_q, wraps_d;
  logic             mismatch_q, mismatch_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] exp_n;
  logic             compare_en;
  logic             miss;

  // Prediction of the monitored counter's next value and the compare decision.
  // A cycle with the monitored clear asserted is a legal discontinuity, so no
  // comparison is made and the state is held.
  always_comb begin
    exp_n = mon_data;
    if (!mon_nreset) begin
      exp_n = '0;
    end else if (mon_enable) begin
      exp_n = mon_data + WIDTH'(1);
    end
    compare_en = (state_q != ACQUIRE) && mon_nreset;
    miss       = compare_en && (mon_data != expected_q);
  end

  // Next-state, prediction reload (always, including resync after a miss),
  // wrap counting and sticky error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACQUIRE: state_d = TRACK;
      TRACK:   if (compare_en && miss)  state_d = FAULT;
      FAULT:   if (compare_en && !miss) state_d = TRACK;
      default: state_d = ACQUIRE;
    endcase

    expected_d = exp_n;
    mismatch_d = miss;

    wraps_d = wraps_q;
    if ((state_q != ACQUIRE) && mon_nreset && mon_enable && (mon_data == '1)) begin
      wraps_d = wraps_q + WIDTH'(1);
    end

    error_d = error_q;
    if (miss) begin
      error_d = 1'b1;
    end else if (clear_err) begin
      error_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACQUIRE;
      expected_q <= '0;
      wraps_q    <= '0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      wraps_q    <= wraps_d;
      mismatch_q <= mismatch_d;
      error_q    <= error_d;
    end
  end

  sat_counter #(
    .WIDTH (ERRCNT_WIDTH)
  ) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (miss),
    .clr   (clear_err),
    .count (err_count)
  );

  assign locked   = (state_q != ACQUIRE);
  assign mismatch = mismatch_q;
  assign error    = error_q;
  assign wraps    = wraps_q;
  assign expected = expected_q;

endmodule

// File: tb/tb_simple_counter_checker.sv
// Randomized and directed bench for simple_counter_checker with a
// behavioural reference model.
module tb_simple_counter_checker;

  logic        clk;
  logic        reset;
  logic        mon_nreset;
  logic        mon_enable;
  logic [15:0] mon_data;
  logic        clear_err;
  logic        locked;
  logic        mismatch;
  logic        error;
  logic [7:0]  err_count;
  logic [15:0] wraps;
  logic [15:0] expected;

  int unsigned n_tests;
  int unsigned n_fail;

  // reference model state
  bit          m_locked;
  logic [15:0] m_exp;
  bit          m_mism;
  bit          m_err;
  int unsigned m_cnt;
  logic [15:0] m_wraps;

  // behavioural monitored counter
  logic [15:0] ctr;

  simple_counter_checker #(
    .WIDTH        (16),
    .ERRCNT_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mon_nreset (mon_nreset),
    .mon_enable (mon_enable),
    .mon_data   (mon_data),
    .clear_err  (clear_err),
    .locked     (locked),
    .mismatch   (mismatch),
    .error      (error),
    .err_count  (err_count),
    .wraps      (wraps),
    .expected   (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit nr, input bit en, input logic [15:0] d, input bit clr);
    bit cmp;
    bit miss;
    if (r) begin
      m_locked = 0; m_exp = 16'h0; m_mism = 0; m_err = 0; m_cnt = 0; m_wraps = 16'h0;
    end else begin
      cmp  = m_locked && nr;
      miss = cmp && (d != m_exp);
      if (cmp && en && d == 16'hFFFF) m_wraps = m_wraps + 16'h1;
      if (miss) begin
        m_err = 1;
        if (clr) m_cnt = 1;
        else if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (clr) begin
        m_err = 0;
        m_cnt = 0;
      end
      m_mism   = miss;
      m_exp    = !nr ? 16'h0 : (en ? d + 16'h1 : d);
      m_locked = 1;
    end
  endtask

  task automatic tick(input bit r, input bit nr, input bit en, input logic [15:0] d, input bit clr);
    reset = r; mon_nreset = nr; mon_enable = en; mon_data = d; clear_err = clr;
    @(posedge clk);
    model_step(r, nr, en, d, clr);
    ctr = !nr ? 16'h0 : (en ? d + 16'h1 : d);
    #1;
    check_eq("locked",    {31'b0, locked},   {31'b0, m_locked});
    check_eq("mismatch",  {31'b0, mismatch}, {31'b0, m_mism});
    check_eq("error",     {31'b0, error},    {31'b0, m_err});
    check_eq("err_count", {24'b0, err_count}, m_cnt);
    check_eq("wraps",     {16'b0, wraps},    {16'b0, m_wraps});
    check_eq("expected",  {16'b0, expected}, {16'b0, m_exp});
    @(negedge clk);
  endtask

  // one cycle of a healthy counter
  task automatic run(input bit en, input bit clr);
    tick(0, 1, en, ctr, clr);
  endtask

  initial begin
    int unsigned r;
    bit nr, en, clr, rst;
    logic [15:0] d;
    n_tests = 0; n_fail = 0; ctr = 16'h0;
    reset = 1; mon_nreset = 1; mon_enable = 0; mon_data = 16'h0; clear_err = 0;
    @(negedge clk);

    // reset state
    tick(1, 1, 0, 16'h0, 1);
    tick(1, 1, 1, 16'h5555, 0);
    check_eq("rst_locked", {31'b0, locked}, 32'd0);
    check_eq("rst_errcnt", {24'b0, err_count}, 32'd0);
    check_eq("rst_expected", {16'b0, expected}, 32'd0);

    // clean count from 0
    ctr = 16'h0;
    run(1, 0);
    check_eq("lock_after_1", {31'b0, locked}, 32'd1);
    for (int i = 0; i < 19; i++) run(1, 0);
    check_eq("count_errcnt", {24'b0, err_count}, 32'd0);
    check_eq("count_error", {31'b0, error}, 32'd0);

    // wrap-around from 0xFFFD
    tick(1, 1, 0, 16'h0, 0);
    ctr = 16'hFFFD;
    for (int i = 0; i < 5; i++) run(1, 0);
    check_eq("wrap_count", {16'b0, wraps}, 32'd1);
    check_eq("wrap_nomiss", {31'b0, error}, 32'd0);

    // single glitch at expected 0x0010
    tick(1, 1, 0, 16'h0, 0);
    ctr = 16'h000C;
    for (int i = 0; i < 8 && ctr != 16'h0010; i++) run(1, 0);
    check_eq("glitch_exp", {16'b0, expected}, 32'h10);
    tick(0, 1, 1, 16'h0042, 0);
    check_eq("glitch_pulse", {31'b0, mismatch}, 32'd1);
    check_eq("glitch_error", {31'b0, error}, 32'd1);
    check_eq("glitch_cnt", {24'b0, err_count}, 32'd1);
    check_eq("glitch_resume_data", {16'b0, ctr}, 32'h43);
    run(1, 0);
    check_eq("glitch_one_pulse", {31'b0, mismatch}, 32'd0);
    check_eq("glitch_locked", {31'b0, locked}, 32'd1);
    run(1, 0);
    check_eq("glitch_cnt_hold", {24'b0, err_count}, 32'd1);

    // 300 consecutive mismatches saturate the counter
    for (int i = 0; i < 300; i++) tick(0, 1, 1, ctr + 16'h2, 0);
    check_eq("sat_cnt", {24'b0, err_count}, 32'hFF);
    check_eq("sat_error", {31'b0, error}, 32'd1);
    run(1, 0);
    check_eq("sat_recover", {31'b0, mismatch}, 32'd0);

    // clear vs simultaneous mismatch
    run(1, 1);
    check_eq("clr_error", {31'b0, error}, 32'd0);
    check_eq("clr_cnt", {24'b0, err_count}, 32'd0);
    run(1, 0);
    tick(0, 1, 1, ctr ^ 16'h0100, 1);
    check_eq("clr_miss_error", {31'b0, error}, 32'd1);
    check_eq("clr_miss_cnt", {24'b0, err_count}, 32'd1);
    run(1, 0);
    run(1, 1);
    check_eq("clr_lone_error", {31'b0, error}, 32'd0);
    check_eq("clr_lone_cnt", {24'b0, err_count}, 32'd0);

    // monitored clear mid-count, then checker reset mid-count
    tick(1, 1, 0, 16'h0, 0);
    ctr = 16'h1230;
    for (int i = 0; i < 8 && ctr != 16'h1234; i++) run(1, 0);
    tick(0, 0, 1, 16'h1234, 0);
    check_eq("nrst_expected", {16'b0, expected}, 32'd0);
    check_eq("nrst_nomiss", {31'b0, mismatch}, 32'd0);
    run(1, 0);
    check_eq("nrst_after", {31'b0, mismatch}, 32'd0);
    for (int i = 0; i < 3; i++) run(1, 0);
    tick(1, 1, 1, ctr, 1);
    check_eq("mid_rst_locked", {31'b0, locked}, 32'd0);
    check_eq("mid_rst_wraps", {16'b0, wraps}, 32'd0);
    check_eq("mid_rst_cnt", {24'b0, err_count}, 32'd0);
    run(1, 0);
    check_eq("mid_rst_relock", {31'b0, locked}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r   = $urandom_range(0, 99);
      rst = (r == 0);
      nr  = !(r >= 1 && r <= 3);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      d   = ctr;
      if (r >= 4 && r <= 8) d = ctr ^ 16'($urandom_range(1, 65535));
      if (r == 9) d = 16'hFFF0 + 16'($urandom_range(0, 15));
      if (r == 10) ctr = 16'hFFFE;
      if (r == 10) d = ctr;
      tick(rst, nr, en, d, clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
